// File: rtl/pcsa_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
package pcsa_pkg;

  localparam int PCSA_WIDTH = 16;
  localparam int PCSA_BLOCK = 4;

  // One pipeline stage per BLOCK-wide slice of the operands
  function automatic int pcsa_nstage(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select slice: both carry-in outcomes are computed up front,
// and the incoming carry only drives the final mux.
module csel_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic [BLOCK:0] r0, r1;

  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  // Late-arriving carry selects between the two precomputed results
  assign {co, s} = ci ? r1 : r0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder: WIDTH/BLOCK stages, one slice per stage,
// valid/ready handshake with a full-pipeline stall on output backpressure.
// Signed overflow output is generated only when PCSA_OVERFLOW_EN is defined;
// otherwise ovf is tied low.
module pipelined_csel_adder
  import pcsa_pkg::*;
#(
  parameter int WIDTH = PCSA_WIDTH,
  parameter int BLOCK = PCSA_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NSTAGE = pcsa_nstage(WIDTH, BLOCK);

  if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
    $error("pipelined_csel_adder: WIDTH must be a positive multiple of BLOCK");
  end

  logic              hold;
  logic              fire;
  logic [NSTAGE:1]   vld_pipe;  // vld_pipe[k+1] is the valid bit of stage k
  logic [NSTAGE:1]   cry_pipe;  // carry out registered by stage k

`ifdef PCSA_OVERFLOW_EN
  logic ovf_q;
`endif

  // An unaccepted result freezes every stage, so nothing can enter either
  assign hold     = vld_pipe[NSTAGE] && !out_ready;
  assign in_ready = !hold;
  assign fire     = in_valid && in_ready;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
    localparam int RW = WIDTH - k*BLOCK;   // operand bits not yet added
    localparam int SW = (k+1)*BLOCK;       // sum bits resolved after this stage

    logic [RW-1:0]    opa, opb;
    logic             vin, cs;
    logic [BLOCK-1:0] bs;
    logic             bc;
    logic [SW-1:0]    rs_d, rs;

    if (k == 0) begin : g_src
      assign opa  = A;
      assign opb  = B;
      assign vin  = fire;
      assign cs   = cin;
      assign rs_d = bs;
    end else begin : g_src
      logic [RW-1:0] ska, skb;
      // Skew: untouched upper operand bits ride along with their transfer
      always_ff @(posedge clk) begin
        if (rst) begin
          ska <= '0;
          skb <= '0;
        end else if (!hold) begin
          ska <= g_stg[k-1].opa[RW+BLOCK-1:BLOCK];
          skb <= g_stg[k-1].opb[RW+BLOCK-1:BLOCK];
        end
      end
      assign opa  = ska;
      assign opb  = skb;
      assign vin  = vld_pipe[k];
      assign cs   = cry_pipe[k];
      assign rs_d = {bs, g_stg[k-1].rs};
    end

    csel_block #(.BLOCK(BLOCK)) u_csel (
      .a  (opa[BLOCK-1:0]),
      .b  (opb[BLOCK-1:0]),
      .ci (cs),
      .s  (bs),
      .co (bc)
    );

    // Stage register: valid, carry and the low sum bits resolved so far
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe[k+1] <= 1'b0;
        cry_pipe[k+1] <= 1'b0;
        rs            <= '0;
      end else if (!hold) begin
        vld_pipe[k+1] <= vin;
        cry_pipe[k+1] <= bc;
        rs            <= rs_d;
      end
    end

`ifdef PCSA_OVERFLOW_EN
    if (k == NSTAGE-1) begin : g_ovf
      // Operand MSBs and the sum MSB all live in the final slice
      always_ff @(posedge clk) begin
        if (rst)
          ovf_q <= 1'b0;
        else if (!hold)
          ovf_q <= (opa[RW-1] == opb[RW-1]) && (bs[BLOCK-1] != opa[RW-1]);
      end
    end
`endif
  end

  assign sum       = g_stg[NSTAGE-1].rs;
  assign carry     = cry_pipe[NSTAGE];
  assign out_valid = vld_pipe[NSTAGE];

`ifdef PCSA_OVERFLOW_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder (WIDTH=16, BLOCK=4).
// Expected results come from plain integer arithmetic held in a FIFO.
module tb_pipelined_csel_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, cin, in_valid, out_ready;
  logic [W-1:0] A, B;
  logic         in_ready, carry, ovf, out_valid;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carry(carry), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [17:0] q[$];          // {carry, ovf, sum} in issue order
  logic        was_stall = 1'b0;
  logic [17:0] held;
  logic [15:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    int unsigned t;
    int          r;
    logic        o;
    t = int'(a) + int'(b) + int'(ci);
    r = int'($signed(a)) + int'($signed(b)) + int'(ci);
    o = (r > 32767) || (r < -32768);
`ifndef PCSA_OVERFLOW_EN
    o = 1'b0;
`endif
    return {t[16], o, t[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshake/stability/ordering, record transfers, advance
  task automatic tick();
    logic st;
    #1;
    chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
    if (!rst) begin
      st = out_valid && !out_ready;
      if (st && was_stall) chk("stall_stable", {14'd0, carry, ovf, sum}, {14'd0, held});
      if (st) held = {carry, ovf, sum};
      was_stall = st;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
        else               chk("result_order", {14'd0, carry, ovf, sum}, {14'd0, q.pop_front()});
      end
      if (in_valid && in_ready) q.push_back(model(A, B, cin));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic o28;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; A = 16'h1234; B = 16'h1111; cin = 1'b0;

    // Reset held two cycles
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0; q.delete(); was_stall = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       {16'd0, sum},       32'd0);
    chk("rst_carry",     {31'd0, carry},     32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // Carry out of the MSB, latency exactly 4
    A = 16'hFFFF; B = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lat27_early", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("lat27_valid", {31'd0, out_valid}, 32'd1);
    chk("r27_sum",     {16'd0, sum},       32'h0000);
    chk("r27_carry",   {31'd0, carry},     32'd1);
    chk("r27_ovf",     {31'd0, ovf},       32'd0);
    tick();

    // Signed overflow
`ifdef PCSA_OVERFLOW_EN
    o28 = 1'b1;
`else
    o28 = 1'b0;
`endif
    A = 16'h7FFF; B = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lat28_early", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("lat28_valid", {31'd0, out_valid}, 32'd1);
    chk("r28_sum",     {16'd0, sum},       32'h8000);
    chk("r28_carry",   {31'd0, carry},     32'd0);
    chk("r28_ovf",     {31'd0, ovf},       {31'd0, o28});
    tick();

    // Back-to-back with a 3-cycle stall on the first result
    out_ready = 1'b0;
    A = 16'h0505; B = 16'h0303; cin = 1'b1; in_valid = 1'b1;
    tick();
    A = 16'h1111; B = 16'h2222; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8 && !out_valid; i++) tick();
    chk("r29_first_valid", {31'd0, out_valid}, 32'd1);
    A = 16'h4444; B = 16'h0001; in_valid = 1'b1;   // must not enter while stalled
    for (int i = 0; i < 3; i++) begin
      chk("r29_stall_ready", {31'd0, in_ready}, 32'd0);
      chk("r29_stall_sum",   {16'd0, sum},      32'h0809);
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    chk("r29_first_sum", {16'd0, sum}, 32'h0809);
    tick();
    chk("r29_second_valid", {31'd0, out_valid}, 32'd1);
    chk("r29_second_sum",   {16'd0, sum},       32'h3333);
    tick();
    chk("r29_drained", {31'd0, out_valid}, 32'd0);

    // Reset two cycles after a transfer discards it
    A = 16'h0F0F; B = 16'h0101; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; q.delete(); was_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("r30_discard", {31'd0, out_valid}, 32'd0);
      tick();
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      A   = ($urandom % 5 == 0) ? corner[$urandom % 4] : 16'($urandom);
      B   = ($urandom % 5 == 0) ? corner[$urandom % 4] : 16'($urandom);
      cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain_all_results", q.size(), 32'd0);
    chk("drain_idle",        {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_csel_adder.md
PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/sum width in bits.
REQ-002 SHALL have parameter BLOCK, default 4: carry-select slice width; WIDTH SHALL be an integer multiple of BLOCK, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports A, B, input, WIDTH: operands, unsigned bit vectors, two's-complement for overflow.
REQ-006 SHALL have port cin, input, 1: carry in.
REQ-007 SHALL have port in_valid, input, 1, and port in_ready, output, 1: input handshake.
REQ-008 SHALL have port sum, output, WIDTH; port carry, output, 1 (carry out of MSB); port ovf, output, 1 (signed overflow).
REQ-009 SHALL have port out_valid, output, 1, and port out_ready, input, 1: output handshake.

Function
REQ-010 SHALL have NSTAGE = WIDTH/BLOCK pipeline stages; stage k adds bits [k*BLOCK +: BLOCK].
REQ-011 Each stage SHALL compute its slice twice (carry-in 0 and 1) and select using the carry registered by stage k-1; stage 0 SHALL use cin.
REQ-012 Upper operand slices SHALL travel in skew registers so that stage k sees operands captured in the same transfer as stage 0.
REQ-013 A transfer SHALL occur when in_valid && in_ready; the result for that transfer SHALL appear with out_valid=1 exactly NSTAGE cycles later when no stall occurs.
REQ-014 sum/carry SHALL equal (A + B + cin) mod 2^WIDTH and bit WIDTH respectively; ovf SHALL equal (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]).
REQ-015 Each stage SHALL carry a valid bit; bubbles SHALL propagate as invalid entries.
REQ-016 Stall: when out_valid && !out_ready, the whole pipeline SHALL hold, and in_ready SHALL be 0.
REQ-017 in_ready SHALL equal !(out_valid && !out_ready) (combinational); throughput SHALL be one result per cycle with no stall.
REQ-018 sum/carry/ovf SHALL remain stable while out_valid && !out_ready.
REQ-019 Results SHALL leave in input order; no transfer SHALL be dropped or duplicated.
REQ-020 Simultaneous output acceptance and input transfer in the same cycle SHALL both occur.

Reset
REQ-021 While rst=1, at the next edge all stage valid bits, out_valid, sum, carry and ovf SHALL be 0; in-flight operations SHALL be discarded.
REQ-022 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-023 With PCSA_OVERFLOW_EN defined, ovf SHALL follow REQ-014; without it, ovf SHALL be tied 0 and no overflow logic SHALL be generated; the port list SHALL be identical in both cases.

Structure
REQ-024 Package pcsa_pkg SHALL hold default WIDTH/BLOCK constants and the NSTAGE computation function.
REQ-025 Sub-module csel_block (combinational, BLOCK-wide dual ripple add plus select mux) SHALL be instantiated once per stage.

Verification (WIDTH=16, BLOCK=4, latency 4)
REQ-026 rst held 2 cycles -> out_valid=0, sum=0x0000, carry=0, ovf=0; in_ready=1 after release.
REQ-027 A=0xFFFF, B=0x0001, cin=0 -> 4 cycles later sum=0x0000, carry=1, ovf=0.
REQ-028 A=0x7FFF, B=0x0001, cin=0 -> sum=0x8000, carry=0, ovf=1 with PCSA_OVERFLOW_EN, ovf=0 without it.
REQ-029 Back-to-back transfers 0x0505+0x0303 (cin=1), then 0x1111+0x2222 (cin=0), with out_ready=0 for 3 cycles on the first result -> 0x0809 held stable, in_ready=0 during the stall, then 0x3333 next; order is preserved.
REQ-030 rst asserted 2 cycles after a transfer -> out_valid stays 0; that result never appears.
